onehot_mux_reg: RTL
===================

ONEHOT_MUX_REG -- requirements
Module: onehot_mux_reg

Interface
REQ-001 SHALL provide parameter N_CH, default 16, number of input channels (2..64).
REQ-002 SHALL provide parameter W, default 4, channel data width (1..64).
REQ-003 SHALL provide parameter CH_MASK, N_CH bits, default 16'h7FFE, where a 1 marks a populated channel.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  request beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 enable  input  1  mux enable, sampled with beat.
REQ-010 sel  input  N_CH  one-hot channel select, sampled with beat.
REQ-011 din  input  N_CH*W  channel data; channel k at bits [k*W+W-1:k*W].
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 dout  output  W  selected data.
REQ-015 out_idx  output  max(1,$clog2(N_CH))  binary index of selected channel.
REQ-016 out_err  output  1  beat had illegal select.
REQ-017 err_clr  input  1  synchronous clear of err_cnt.
REQ-018 err_cnt  output  8  saturating illegal-select count (see Configuration).

Function
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational, one result register).
REQ-020 SHALL accept a beat when in_valid && in_ready; result appears on dout/out_idx/out_err with out_valid=1 the next cycle (latency 1).
REQ-021 SHALL hold dout, out_idx, out_err, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after out_ready when no new beat is accepted in the same cycle; accept-and-drain in one cycle SHALL replace the result with no bubble.
REQ-023 Accepted beat, enable=0: dout=0, out_idx=0, out_err=0.
REQ-024 Accepted beat, enable=1, sel exactly one-hot at bit k with CH_MASK[k]=1: dout=channel k data, out_idx=k, out_err=0.
REQ-025 Accepted beat, enable=1, sel zero, multi-hot, or hot on an unpopulated bit: dout=0, out_idx=0, out_err=1.
REQ-026 SHALL ignore in_valid, sel, enable and din when no beat is accepted.

Reset
REQ-027 On rst_n low, SHALL immediately force out_valid=0, dout=0, out_idx=0, out_err=0, err_cnt=0, independent of clk.
REQ-028 A beat pending or held at reset assertion SHALL be discarded; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-029 Macro ONEHOT_MUX_REG_ERRCNT_EN SHALL control the error counter.
REQ-030 With macro defined: err_cnt SHALL increment by 1 per accepted beat producing out_err=1, saturate at 255, clear to 0 on err_clr; err_clr with a simultaneous increment SHALL yield 0.
REQ-031 Without macro: err_cnt SHALL be constant 0, err_clr ignored, no counter flops; all other behaviour identical.

Verification (N_CH=16, W=4, CH_MASK=16'h7FFE, macro defined)
REQ-032 Reset release; enable=1, sel=16'h0002, din channel1=4'hA, out_ready=1 -> next cycle out_valid=1, dout=4'hA, out_idx=1, out_err=0.
REQ-033 sel=16'h8000 (channel 15 unpopulated), enable=1 -> dout=0, out_err=1, err_cnt 0->1; sel=16'h0006 -> out_err=1, err_cnt=2.
REQ-034 out_ready=0 with result held, in_valid=1 with new sel -> in_ready=0, dout unchanged for 3 cycles; out_ready=1 -> new beat accepted same cycle, next result follows with no bubble.
REQ-035 260 consecutive illegal beats -> err_cnt saturates at 255; err_clr=1 with illegal beat in same cycle -> err_cnt=0.
REQ-036 enable=0, sel=16'h0004, channel2=4'h5 -> dout=0, out_err=0; rst_n pulsed low mid-held-result -> out_valid=0 immediately, err_cnt=0.

Source files
------------

// File: rtl/onehot_mux_reg.sv
// One-hot select mux with a single registered, ready/valid result stage.
// Define ONEHOT_MUX_REG_ERRCNT_EN to build the saturating illegal-select counter.

module onehot_mux_reg_lane #(
  parameter int W  = 4,
  parameter int IW = 4,
  parameter int K  = 0
) (
  input  logic          sel_bit,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [IW-1:0] idx
);
  // Each lane contributes its data and constant index only when its select
  // bit is hot; the top ORs every lane together.
  assign dout = sel_bit ? din     : '0;
  assign idx  = sel_bit ? IW'(K) : '0;
endmodule

module onehot_mux_reg #(
  parameter int              N_CH    = 16,
  parameter int              W       = 4,
  parameter logic [N_CH-1:0] CH_MASK = 16'h7FFE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 enable,
  input  logic [N_CH-1:0]                      sel,
  input  logic [N_CH*W-1:0]                    din,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [W-1:0]                         dout,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_idx,
  output logic                                 out_err,
  input  logic                                 err_clr,
  output logic [7:0]                           err_cnt
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          err;
  } rsp_t;

  logic [N_CH-1:0][W-1:0]  w_din_ch;
  logic [N_CH-1:0][W-1:0]  w_lane_data;
  logic [N_CH-1:0][IW-1:0] w_lane_idx;
  logic [W-1:0]            w_or_data;
  logic [IW-1:0]           w_or_idx;
  logic                    w_onehot;
  logic                    w_in_mask;
  logic                    w_pass;
  logic                    w_err;
  logic                    w_accept;
  rsp_t                    w_nxt;
  rsp_t                    r_rsp;
  logic                    r_out_valid;

  assign w_din_ch = din;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    onehot_mux_reg_lane #(.W(W), .IW(IW), .K(k)) u_lane (
      .sel_bit (sel[k]),
      .din     (w_din_ch[k]),
      .dout    (w_lane_data[k]),
      .idx     (w_lane_idx[k])
    );
  end

  always_comb begin
    w_or_data = '0;
    w_or_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_or_data = w_or_data | w_lane_data[k];
      w_or_idx  = w_or_idx  | w_lane_idx[k];
    end
  end

  // The OR of all lanes is only meaningful when exactly one populated bit is hot.
  assign w_onehot  = (sel != '0) && ((sel & (sel - N_CH'(1))) == '0);
  assign w_in_mask = (sel & ~CH_MASK) == '0;
  assign w_pass    = enable && w_onehot && w_in_mask;
  assign w_err     = enable && !(w_onehot && w_in_mask);

  always_comb begin
    w_nxt      = '0;
    w_nxt.data = w_pass ? w_or_data : '0;
    w_nxt.idx  = w_pass ? w_or_idx  : '0;
    w_nxt.err  = w_err;
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rsp       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rsp       <= w_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_rsp.data;
  assign out_idx   = r_rsp.idx;
  assign out_err   = r_rsp.err;

`ifdef ONEHOT_MUX_REG_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (err_clr)
      r_err_cnt <= '0;
    else if (w_accept && w_err && (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err_cnt          = '0;
`endif

endmodule
